// File: rtl/cipher_block_serializer_if.sv
// Encrypter-to-serializer block bus and serializer-to-link byte bus.
// Both sides use valid/ready. A transfer happens on a rising edge where valid and ready are both high. Valid, once raised, holds with stable payload until that transfer.
interface cipher_block_serializer_if #(
  parameter int BLK_W = 96
);
  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_sob;
  logic             out_eob;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sob, out_eob
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sob, out_eob
  );
endinterface

// File: rtl/cipher_block_serializer.sv
// Buffers ciphertext blocks in a small FIFO and streams them MSB byte first with sob/eob markers.
// Define CIPHER_PARITY_EN to append an XOR parity byte (carrying eob) after every block.
module cipher_block_serializer #(
  parameter int BLK_W = 96,
  parameter int DEPTH = 2
) (
  input  logic                         Clk,
  input  logic                         Rst,
  cipher_block_serializer_if.slave     bus,
  output logic [15:0]                  blk_count,
  output logic [1:0]                   state_dbg
);
  localparam int NBYTES = BLK_W / 8;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [IW-1:0] PREV_IDX = IW'(NBYTES - 2);

`ifdef CIPHER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t              state;
  logic [BLK_W-1:0]    mem [DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic [BLK_W-9:0]    rem;
  logic [IW-1:0]       byte_idx;
  logic                full, empty, push, pop, blk_done;
  logic [BLK_W-1:0]    head;
`ifdef CIPHER_PARITY_EN
  logic [7:0]          par;
`endif

  // Extra pointer bit tells a full FIFO from an empty one when the indices match.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign head         = mem[rd_ptr[AW-1:0]];
  assign state_dbg    = state;

  always_comb begin
    blk_done = 1'b0;
    case (state)
`ifdef CIPHER_PARITY_EN
      PAR:     blk_done = bus.out_ready;
`else
      SEND:    blk_done = bus.out_ready && (byte_idx == LAST_IDX);
`endif
      default: blk_done = 1'b0;
    endcase
    pop = !empty && ((state == IDLE) || blk_done);
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rem           <= '0;
      byte_idx      <= '0;
      blk_count     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sob   <= 1'b0;
      bus.out_eob   <= 1'b0;
`ifdef CIPHER_PARITY_EN
      par           <= '0;
`endif
    end else begin
      if (push)     wr_ptr    <= wr_ptr + (AW+1)'(1);
      if (pop)      rd_ptr    <= rd_ptr + (AW+1)'(1);
      if (blk_done) blk_count <= blk_count + 16'd1;

      if (pop) begin
        // Load covers both the IDLE start and the gap-free hand-over at block end.
        state         <= SEND;
        rem           <= head[BLK_W-9:0];
        byte_idx      <= '0;
        bus.out_valid <= 1'b1;
        bus.out_data  <= head[BLK_W-1 -: 8];
        bus.out_sob   <= 1'b1;
`ifdef CIPHER_PARITY_EN
        bus.out_eob   <= 1'b0;
        par           <= '0;
`else
        bus.out_eob   <= (NBYTES == 1);
`endif
      end else begin
        case (state)
          SEND: if (bus.out_ready) begin
            if (byte_idx == LAST_IDX) begin
`ifdef CIPHER_PARITY_EN
              state         <= PAR;
              bus.out_data  <= par ^ bus.out_data;
              bus.out_sob   <= 1'b0;
              bus.out_eob   <= 1'b1;
`else
              state         <= IDLE;
              bus.out_valid <= 1'b0;
              bus.out_data  <= '0;
              bus.out_sob   <= 1'b0;
              bus.out_eob   <= 1'b0;
`endif
            end else begin
              rem           <= rem << 8;
              bus.out_data  <= rem[BLK_W-9 -: 8];
              byte_idx      <= byte_idx + IW'(1);
              bus.out_sob   <= 1'b0;
`ifdef CIPHER_PARITY_EN
              par           <= par ^ bus.out_data;
              bus.out_eob   <= 1'b0;
`else
              bus.out_eob   <= (byte_idx == PREV_IDX);
`endif
            end
          end
`ifdef CIPHER_PARITY_EN
          PAR: if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sob   <= 1'b0;
            bus.out_eob   <= 1'b0;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cipher_block_serializer.sv
// Bench for cipher_block_serializer: vector table, corner sequences, byte scoreboard.
// Define CIPHER_PARITY_EN here too when the DUT is built with parity.
module tb_cipher_block_serializer;
`ifdef CIPHER_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  localparam int BPB = PAR_ON ? 13 : 12;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] blk_count;
  logic [1:0]  state_dbg;

  cipher_block_serializer_if #(.BLK_W(96)) bus ();

  cipher_block_serializer #(.BLK_W(96), .DEPTH(2)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .bus       (bus),
    .blk_count (blk_count),
    .state_dbg (state_dbg)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];   // {sob, eob, data}

  int cyc = 0, acc_cnt = 0, v_cnt = 0, first_v = -1, last_v = -1;
  logic [7:0] last_sob_byte, last_eob_byte;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_word;
  logic [9:0] got, want;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [95:0] b);
    logic [7:0] p;
    logic [7:0] d;
    p = '0;
    for (int i = 0; i < 12; i++) begin
      d = b[95-8*i -: 8];
      p ^= d;
      exp_q.push_back({(i == 0), ((i == 11) && !PAR_ON), d});
    end
`ifdef CIPHER_PARITY_EN
    exp_q.push_back({1'b0, 1'b1, p});
`endif
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the block.
  task automatic push_block(input logic [95:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 300; k++) begin
      @(negedge Clk);
      if (bus.in_ready) begin
        exp_push(b);
        @(posedge Clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL push_timeout got in_ready=0 want 1");
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 600; k++) begin
      @(negedge Clk);
      if (exp_q.size() == 0 && !bus.out_valid) return;
    end
    checks++; errors++;
    $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
  endtask

  // Scoreboard and hold-stability monitor.
  always @(negedge Clk) begin
    cyc++;
    if (Rst) begin
      prev_stall = 1'b0;
    end else begin
      got = {bus.out_sob, bus.out_eob, bus.out_data};
      if (prev_stall) begin
        checks++;
        if (!bus.out_valid || got !== prev_word) begin
          errors++;
          $display("FAIL hold_stable got v=%0b %0h want v=1 %0h", bus.out_valid, got, prev_word);
        end
      end
      if (bus.out_valid) begin
        v_cnt++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        acc_cnt++;
        checks++;
        if (bus.out_sob) last_sob_byte = bus.out_data;
        if (bus.out_eob) last_eob_byte = bus.out_data;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte_unexpected got %0h want none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL byte got %0h want %0h", got, want);
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = got;
    end
  end

  typedef struct {
    logic [95:0] blk;
    logic [7:0]  first_b;
    logic [7:0]  last_d;
    logic [7:0]  par;
  } vec_t;

  vec_t        vecs[4];
  logic [95:0] rb[4];
  logic [15:0] exp_blk;
  logic        pushes_done;
  int          base, seen;

  initial begin
    vecs[0] = '{96'h0102030405060708090A0B0C, 8'h01, 8'h0C, 8'h0C};
    vecs[1] = '{96'hFFFFFFFFFFFFFFFFFFFFFFFF, 8'hFF, 8'hFF, 8'h00};
    vecs[2] = '{96'h800000000000000000000001, 8'h80, 8'h01, 8'h81};
    vecs[3] = '{96'h000000000000000000000000, 8'h00, 8'h00, 8'h00};
    exp_blk = 16'd0;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_sob",   32'(bus.out_sob),   32'd0);
    chk("rst_out_eob",   32'(bus.out_eob),   32'd0);
    chk("rst_blk_count", 32'(blk_count),     32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge Clk); #1;

    // Single blocks from the table, checking first-byte latency and markers.
    for (int i = 0; i < 4; i++) begin
      push_block(vecs[i].blk);
      @(negedge Clk);
      chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
      @(negedge Clk);
      chk("lat_first_valid", 32'({bus.out_valid, bus.out_sob, bus.out_data}), 32'({2'b11, vecs[i].first_b}));
      drain();
      exp_blk++;
      chk("vec_sob_byte", 32'(last_sob_byte), 32'(vecs[i].first_b));
      chk("vec_eob_byte", 32'(last_eob_byte), 32'(PAR_ON ? vecs[i].par : vecs[i].last_d));
      chk("vec_blk_count", 32'(blk_count), 32'(exp_blk));
      @(posedge Clk); #1;
    end

    // Back-to-back blocks: one unbroken valid run.
    v_cnt = 0; first_v = -1; last_v = -1;
    push_block(96'hA0A1A2A3A4A5A6A7A8A9AAAB);
    push_block(96'hB0B1B2B3B4B5B6B7B8B9BABB);
    drain();
    exp_blk += 16'd2;
    chk("b2b_valid_cnt", 32'(v_cnt), 32'(2 * BPB));
    chk("b2b_contiguous", 32'(last_v - first_v + 1), 32'(2 * BPB));
    chk("b2b_blk_count", 32'(blk_count), 32'(exp_blk));
    @(posedge Clk); #1;

    // Backpressure until the FIFO is full, then a held fourth block.
    bus.out_ready = 1'b0;
    push_block(96'hC0C1C2C3C4C5C6C7C8C9CACB);
    push_block(96'hD0D1D2D3D4D5D6D7D8D9DADB);
    push_block(96'hE0E1E2E3E4E5E6E7E8E9EAEB);
    bus.in_valid = 1'b1;
    bus.in_data  = 96'hF0F1F2F3F4F5F6F7F8F9FAFB;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      chk("full_hold_byte", 32'({bus.out_valid, bus.out_sob, bus.out_data}), 32'({2'b11, 8'hC0}));
    end
    @(posedge Clk); #1;
    bus.out_ready = 1'b1;
    push_block(96'hF0F1F2F3F4F5F6F7F8F9FAFB);
    drain();
    exp_blk += 16'd4;
    chk("full_blk_count", 32'(blk_count), 32'(exp_blk));
    @(posedge Clk); #1;

    // Random 50% stalls over four random blocks.
    for (int b = 0; b < 4; b++) rb[b] = {$urandom, $urandom, $urandom};
    pushes_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 4; b++) push_block(rb[b]);
        pushes_done = 1'b1;
      end
      begin
        for (int k = 0; k < 2000 && !(pushes_done && exp_q.size() == 0); k++) begin
          @(posedge Clk); #1;
          bus.out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    exp_blk += 16'd4;
    chk("stall_blk_count", 32'(blk_count), 32'(exp_blk));
    @(posedge Clk); #1;

    // Reset after five accepted bytes; the queued block must vanish.
    base = acc_cnt;
    push_block(96'h1112131415161718191A1B1C);
    push_block(96'h2122232425262728292A2B2C);
    for (int k = 0; k < 100 && (acc_cnt - base) < 5; k++) @(negedge Clk);
    chk("mid_bytes_before_rst", 32'(acc_cnt - base), 32'd5);
    @(posedge Clk); #1 Rst = 1'b1;
    @(posedge Clk); #1 Rst = 1'b0;
    exp_q.delete();
    exp_blk = 16'd0;
    @(negedge Clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_blk_count", 32'(blk_count), 32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge Clk);
      if (bus.out_valid) seen++;
    end
    chk("mid_rst_no_output", 32'(seen), 32'd0);
    @(posedge Clk); #1;

    // Counter wrap with a preloaded count.
    force dut.blk_count = 16'hFFFF;
    @(posedge Clk); #1;
    release dut.blk_count;
    push_block(96'h3132333435363738393A3B3C);
    drain();
    chk("wrap_blk_count", 32'(blk_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
